bp_update_ctrl: RTL and testbench
=================================

BP_UPDATE_CTRL -- requirements
Module: bp_update_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, in-flight queue entries (power of two, >=2).
REQ-002 Parameter GHR_W, default 12, global history width.
REQ-003 Parameter PC_W, default 32, branch PC width.
REQ-004 clock  input  1  sole clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 pred_valid/pred_ready  input/output  1/1  prediction-issue handshake.
REQ-007 pred_pc, pred_ghr, pred_local, pred_global, pred_final  input  PC_W/GHR_W/1/1/1  issued PC, GHR snapshot, component predictions, tournament result.
REQ-008 res_valid/res_ready  input/output  1/1  in-order resolve handshake; res_taken input 1, actual outcome.
REQ-009 upd_valid/upd_ready  output/input  1/1  single table-write port handshake.
REQ-010 upd_sel output 2 (LOCAL=0, GLOBAL=1, CHOICE=2); upd_pc output PC_W; upd_ghr output GHR_W; upd_taken output 1 (for CHOICE: 1 = global correct).
REQ-011 ghr_restore_valid output 1; ghr_restore_value output GHR_W; flush output 1.
REQ-012 count output $clog2(DEPTH)+1, current queue occupancy.

Function
REQ-013 Queue SHALL push {pc, ghr, local, global, final} on pred_valid&&pred_ready; pred_ready = (count<DEPTH) && state!=RECOVER, independent of same-cycle pop.
REQ-014 res_ready SHALL be 1 only when count>0 and state==IDLE; acceptance pops head into working register in the same edge.
REQ-015 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-016 FSM states: IDLE, UPD_LOCAL, UPD_GLOBAL, UPD_CHOICE, RECOVER.
REQ-017 IDLE->UPD_LOCAL on resolve acceptance; upd_valid asserted first in the following cycle.
REQ-018 Each UPD_* state holds upd_valid=1 with stable outputs until upd_ready; advances LOCAL->GLOBAL->CHOICE on handshake.
REQ-019 upd_pc/upd_ghr SHALL be working-register pc/ghr; upd_taken = res_taken for LOCAL/GLOBAL, (global==res_taken) for CHOICE.
REQ-020 After CHOICE handshake: if final!=res_taken go RECOVER, else IDLE.
REQ-021 RECOVER lasts exactly one cycle: ghr_restore_valid=1, ghr_restore_value={ghr[GHR_W-2:0], res_taken}, flush=1; queue emptied (count=0 next cycle); then IDLE.
REQ-022 Predictions pushed during UPD_* states SHALL be discarded by a subsequent RECOVER.
REQ-023 upd_valid, ghr_restore_valid, flush SHALL be 0 in IDLE.

Reset
REQ-024 On reset low: state=IDLE, pointers/count=0, upd_valid=0, ghr_restore_valid=0, flush=0, pred_ready=0 while asserted, res_ready=0, data outputs 0.
REQ-025 Reset mid-update SHALL abandon the update with no further upd_valid after release.
REQ-026 First pred_ready=1 the cycle after reset deasserts.

Configuration
REQ-027 Macro BP_UPD_CHOICE_FILTER_EN: when defined, UPD_CHOICE is skipped (GLOBAL handshake goes directly to RECOVER/IDLE per REQ-020) if local==global; when undefined, UPD_CHOICE is always issued.

Structure
REQ-028 Shared package bp_pkg SHALL hold upd_sel enum, FSM state enum, and in-flight entry struct typedef.
REQ-029 Queue SHALL be sub-module bp_inflight_fifo (parameterised DEPTH, entry type); FSM and working register in bp_update_ctrl.

Verification
REQ-030 Push 3 predictions, resolve first correct (final=1, taken=1, upd_ready=1) -> upd_sel 0,1,2 in three consecutive cycles, no flush, count=2.
REQ-031 Mispredict: entry ghr=12'h0A5, final=1, res_taken=0 -> RECOVER pulse, ghr_restore_value=12'h14A, flush=1, count=0 next cycle.
REQ-032 Fill DEPTH=8 -> pred_ready=0; push+resolve same cycle at full -> push rejected, count=7.
REQ-033 Hold upd_ready=0 for 5 cycles in UPD_GLOBAL -> upd_valid and outputs stable, res_ready=0 throughout.
REQ-034 With BP_UPD_CHOICE_FILTER_EN, local=global=1 correct resolve -> only two update handshakes; without it, three.
REQ-035 Assert reset during UPD_LOCAL -> all outputs per REQ-024, count=0, no upd_valid after release until next resolve.

Source files
------------

// File: rtl/bp_update_ctrl_pkg.sv
// bp_pkg: shared types for the branch-predictor update controller.
//   upd_sel_e  : which predictor table the single write port targets
//   state_e    : update-sequencer FSM states
//   inflight_t : one issued prediction waiting to be resolved
// The entry fields are sized by BP_PC_W/BP_GHR_W; the controller's PC_W and
// GHR_W parameters must not exceed these widths.
package bp_pkg;

  localparam int BP_PC_W  = 32;
  localparam int BP_GHR_W = 12;

  typedef enum logic [1:0] {
    SEL_LOCAL  = 2'd0,
    SEL_GLOBAL = 2'd1,
    SEL_CHOICE = 2'd2
  } upd_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UPD_LOCAL,
    ST_UPD_GLOBAL,
    ST_UPD_CHOICE,
    ST_RECOVER
  } state_e;

  typedef struct packed {
    logic [BP_PC_W-1:0]  pc;
    logic [BP_GHR_W-1:0] ghr;
    logic                local_pred;
    logic                global_pred;
    logic                final_pred;
  } inflight_t;

  // True in any of the three table-write states.
  function automatic logic is_upd_state(state_e s);
    return (s == ST_UPD_LOCAL) || (s == ST_UPD_GLOBAL) || (s == ST_UPD_CHOICE);
  endfunction

endpackage

// File: rtl/bp_update_ctrl_if.sv
// bp_update_ctrl_if: bundle of the predictor-update controller's handshakes.
//   pred_* : prediction issue (valid/ready + PC, GHR snapshot, predictions)
//   res_*  : in-order resolve (valid/ready + actual outcome)
//   upd_*  : single table-write port (valid/ready + select, PC, GHR, taken)
//   ghr_restore_*, flush : misprediction recovery outputs
//   count  : in-flight queue occupancy
// Modport slave is the controller's view; master is the environment's view.
interface bp_update_ctrl_if
  import bp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int GHR_W = BP_GHR_W,
  parameter int PC_W  = BP_PC_W
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             pred_valid;
  logic             pred_ready;
  logic [PC_W-1:0]  pred_pc;
  logic [GHR_W-1:0] pred_ghr;
  logic             pred_local;
  logic             pred_global;
  logic             pred_final;

  logic             res_valid;
  logic             res_ready;
  logic             res_taken;

  logic             upd_valid;
  logic             upd_ready;
  logic [1:0]       upd_sel;
  logic [PC_W-1:0]  upd_pc;
  logic [GHR_W-1:0] upd_ghr;
  logic             upd_taken;

  logic             ghr_restore_valid;
  logic [GHR_W-1:0] ghr_restore_value;
  logic             flush;
  logic [CW-1:0]    count;

  modport slave (
    input  pred_valid, pred_pc, pred_ghr, pred_local, pred_global, pred_final,
    output pred_ready,
    input  res_valid, res_taken,
    output res_ready,
    output upd_valid, upd_sel, upd_pc, upd_ghr, upd_taken,
    input  upd_ready,
    output ghr_restore_valid, ghr_restore_value, flush, count
  );

  modport master (
    output pred_valid, pred_pc, pred_ghr, pred_local, pred_global, pred_final,
    input  pred_ready,
    output res_valid, res_taken,
    input  res_ready,
    input  upd_valid, upd_sel, upd_pc, upd_ghr, upd_taken,
    output upd_ready,
    input  ghr_restore_valid, ghr_restore_value, flush, count
  );

endinterface

// File: rtl/bp_update_ctrl_fifo.sv
// bp_inflight_fifo: circular queue of in-flight predictions.
//   clock, reset (async, active-low)
//   push/push_data : enqueue (caller guarantees not full)
//   pop            : dequeue head (caller guarantees not empty)
//   clear          : drop every entry (wins over push/pop)
//   head           : oldest entry, valid whenever count > 0
//   count          : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module bp_inflight_fifo
  import bp_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = inflight_t,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          clear,
  output entry_t        head,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage has no reset; an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; a push and pop together keep count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: sequences predictor-table updates for resolved branches.
// Each resolved branch produces LOCAL, GLOBAL and CHOICE writes on the single
// table port, then a one-cycle RECOVER (GHR restore + flush) if the final
// prediction was wrong.
//   clock : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : bp_update_ctrl_if.slave (prediction, resolve, update, recovery)
// Build option: BP_UPD_CHOICE_FILTER_EN skips the CHOICE write when the local
// and global predictions agreed (the chooser learns nothing from it).
module bp_update_ctrl
  import bp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int GHR_W = BP_GHR_W,
  parameter int PC_W  = BP_PC_W
) (
  input  logic             clock,
  input  logic             reset,
  bp_update_ctrl_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e           state;
  state_e           state_next;
  inflight_t        push_entry;
  inflight_t        head_entry;
  inflight_t        work;
  logic             work_taken;
  logic             ready_en;
  logic             can_push;
  logic             can_pop;
  logic             push;
  logic             pop;
  logic             mispredict;
  logic [CW-1:0]    count;
  logic [GHR_W-1:0] work_ghr;

  // Pack the issued prediction into a queue entry.
  always_comb begin
    push_entry             = '0;
    push_entry.pc          = BP_PC_W'(bus.pred_pc);
    push_entry.ghr         = BP_GHR_W'(bus.pred_ghr);
    push_entry.local_pred  = bus.pred_local;
    push_entry.global_pred = bus.pred_global;
    push_entry.final_pred  = bus.pred_final;
  end

  // ready_en keeps pred_ready low during reset and for the release cycle.
  assign can_push = ready_en && (count < CW'(DEPTH)) && (state != ST_RECOVER);
  assign can_pop  = (count != '0) && (state == ST_IDLE);
  assign push     = bus.pred_valid && can_push;
  assign pop      = bus.res_valid && can_pop;

  bp_inflight_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (inflight_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (state == ST_RECOVER),
    .head      (head_entry),
    .count     (count)
  );

  // Enable issue acceptance from the first edge after reset release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Working register: the branch currently being written back.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      work       <= '0;
      work_taken <= 1'b0;
    end else if (pop) begin
      work       <= head_entry;
      work_taken <= bus.res_taken;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  assign mispredict = (work.final_pred != work_taken);
  assign work_ghr   = GHR_W'(work.ghr);

  // Next state and update/recovery outputs; each UPD state holds until upd_ready.
  always_comb begin
    state_next            = state;
    bus.upd_valid         = is_upd_state(state);
    bus.upd_sel           = SEL_LOCAL;
    bus.upd_taken         = work_taken;
    bus.ghr_restore_valid = 1'b0;
    bus.ghr_restore_value = '0;
    bus.flush             = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pop) state_next = ST_UPD_LOCAL;
      end
      ST_UPD_LOCAL: begin
        if (bus.upd_ready) state_next = ST_UPD_GLOBAL;
      end
      ST_UPD_GLOBAL: begin
        bus.upd_sel = SEL_GLOBAL;
        if (bus.upd_ready) begin
`ifdef BP_UPD_CHOICE_FILTER_EN
          if (work.local_pred == work.global_pred)
            state_next = mispredict ? ST_RECOVER : ST_IDLE;
          else
            state_next = ST_UPD_CHOICE;
`else
          state_next = ST_UPD_CHOICE;
`endif
        end
      end
      ST_UPD_CHOICE: begin
        bus.upd_sel   = SEL_CHOICE;
        bus.upd_taken = (work.global_pred == work_taken);
        if (bus.upd_ready) state_next = mispredict ? ST_RECOVER : ST_IDLE;
      end
      ST_RECOVER: begin
        bus.ghr_restore_valid = 1'b1;
        bus.ghr_restore_value = {work_ghr[GHR_W-2:0], work_taken};
        bus.flush             = 1'b1;
        state_next            = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.pred_ready = can_push;
  assign bus.res_ready  = can_pop;
  assign bus.upd_pc     = PC_W'(work.pc);
  assign bus.upd_ghr    = work_ghr;
  assign bus.count      = count;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// tb_bp_update_ctrl: directed self-checking bench for bp_update_ctrl
// (DEPTH=8, GHR_W=12, PC_W=32). Inputs change and outputs are sampled on the
// falling clock edge. Honours BP_UPD_CHOICE_FILTER_EN for the expected
// number of update handshakes.
module tb_bp_update_ctrl;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  bp_update_ctrl_if #(.DEPTH(8), .GHR_W(12), .PC_W(32)) bus ();

  bp_update_ctrl #(.DEPTH(8), .GHR_W(12), .PC_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want $finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_inputs();
    bus.pred_valid  = 1'b0;
    bus.pred_pc     = '0;
    bus.pred_ghr    = '0;
    bus.pred_local  = 1'b0;
    bus.pred_global = 1'b0;
    bus.pred_final  = 1'b0;
    bus.res_valid   = 1'b0;
    bus.res_taken   = 1'b0;
    bus.upd_ready   = 1'b0;
  endtask

  task automatic drive_pred(input logic [31:0] pc, input logic [11:0] ghr,
                            input logic l, input logic g, input logic f);
    bus.pred_valid  = 1'b1;
    bus.pred_pc     = pc;
    bus.pred_ghr    = ghr;
    bus.pred_local  = l;
    bus.pred_global = g;
    bus.pred_final  = f;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Reset values, then pred_ready rising one cycle after release.
  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++; if (bus.pred_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_pred_ready got %0b want 0", bus.pred_ready); end
    checks++; if (bus.res_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_res_ready got %0b want 0", bus.res_ready); end
    checks++; if (bus.upd_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_upd_valid got %0b want 0", bus.upd_valid); end
    checks++; if (bus.flush !== 1'b0 || bus.ghr_restore_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_recover got flush=%0b grv=%0b want 0 0", bus.flush, bus.ghr_restore_valid); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("[TB] FAIL rst_count got %0d want 0", bus.count); end
    checks++; if (bus.upd_pc !== 32'd0 || bus.upd_ghr !== 12'd0 || bus.ghr_restore_value !== 12'd0) begin errors++; $display("[TB] FAIL rst_data got pc=%h ghr=%h rv=%h want 0", bus.upd_pc, bus.upd_ghr, bus.ghr_restore_value); end
    reset = 1'b1;
    #1;
    checks++; if (bus.pred_ready !== 1'b0) begin errors++; $display("[TB] FAIL rel_pred_ready_early got %0b want 0", bus.pred_ready); end
    @(negedge clock);
    checks++; if (bus.pred_ready !== 1'b1) begin errors++; $display("[TB] FAIL rel_pred_ready got %0b want 1", bus.pred_ready); end
    checks++; if (bus.res_ready !== 1'b0) begin errors++; $display("[TB] FAIL rel_res_ready got %0b want 0", bus.res_ready); end
  endtask

  // Three pushes, first resolves correctly: LOCAL, GLOBAL, CHOICE back to back.
  task automatic test_correct();
    do_reset();
    drive_pred(32'h100, 12'h011, 1'b1, 1'b0, 1'b1); @(negedge clock);
    drive_pred(32'h104, 12'h022, 1'b1, 1'b0, 1'b1); @(negedge clock);
    drive_pred(32'h108, 12'h033, 1'b1, 1'b0, 1'b1); @(negedge clock);
    bus.pred_valid = 1'b0;
    checks++; if (bus.count !== 4'd3) begin errors++; $display("[TB] FAIL corr_count3 got %0d want 3", bus.count); end
    checks++; if (bus.res_ready !== 1'b1) begin errors++; $display("[TB] FAIL corr_res_ready got %0b want 1", bus.res_ready); end
    bus.res_valid = 1'b1; bus.res_taken = 1'b1; bus.upd_ready = 1'b1;
    @(negedge clock);
    bus.res_valid = 1'b0;
    checks++; if (bus.upd_valid !== 1'b1 || bus.upd_sel !== 2'd0 || bus.upd_taken !== 1'b1) begin errors++; $display("[TB] FAIL corr_local got v=%0b sel=%0d t=%0b want 1 0 1", bus.upd_valid, bus.upd_sel, bus.upd_taken); end
    checks++; if (bus.upd_pc !== 32'h100 || bus.upd_ghr !== 12'h011) begin errors++; $display("[TB] FAIL corr_data got pc=%h ghr=%h want 100 011", bus.upd_pc, bus.upd_ghr); end
    checks++; if (bus.count !== 4'd2 || bus.res_ready !== 1'b0) begin errors++; $display("[TB] FAIL corr_pop got count=%0d rr=%0b want 2 0", bus.count, bus.res_ready); end
    @(negedge clock);
    checks++; if (bus.upd_valid !== 1'b1 || bus.upd_sel !== 2'd1 || bus.upd_taken !== 1'b1) begin errors++; $display("[TB] FAIL corr_global got v=%0b sel=%0d t=%0b want 1 1 1", bus.upd_valid, bus.upd_sel, bus.upd_taken); end
    @(negedge clock);
    checks++; if (bus.upd_valid !== 1'b1 || bus.upd_sel !== 2'd2 || bus.upd_taken !== 1'b0) begin errors++; $display("[TB] FAIL corr_choice got v=%0b sel=%0d t=%0b want 1 2 0", bus.upd_valid, bus.upd_sel, bus.upd_taken); end
    @(negedge clock);
    checks++; if (bus.upd_valid !== 1'b0 || bus.flush !== 1'b0 || bus.ghr_restore_valid !== 1'b0) begin errors++; $display("[TB] FAIL corr_idle got v=%0b fl=%0b grv=%0b want 0 0 0", bus.upd_valid, bus.flush, bus.ghr_restore_valid); end
    checks++; if (bus.count !== 4'd2) begin errors++; $display("[TB] FAIL corr_count_end got %0d want 2", bus.count); end
  endtask

  // Mispredict: RECOVER pulse restores GHR and flushes a prediction pushed mid-update.
  task automatic test_mispredict();
    do_reset();
    drive_pred(32'h200, 12'h0A5, 1'b1, 1'b0, 1'b1); @(negedge clock);
    bus.pred_valid = 1'b0;
    bus.res_valid = 1'b1; bus.res_taken = 1'b0; bus.upd_ready = 1'b1;
    @(negedge clock);
    bus.res_valid = 1'b0;
    checks++; if (bus.upd_sel !== 2'd0 || bus.upd_taken !== 1'b0 || bus.upd_ghr !== 12'h0A5) begin errors++; $display("[TB] FAIL mis_local got sel=%0d t=%0b ghr=%h want 0 0 0a5", bus.upd_sel, bus.upd_taken, bus.upd_ghr); end
    checks++; if (bus.pred_ready !== 1'b1) begin errors++; $display("[TB] FAIL mis_pred_ready_upd got %0b want 1", bus.pred_ready); end
    drive_pred(32'h204, 12'h0B0, 1'b1, 1'b0, 1'b1);
    @(negedge clock);
    bus.pred_valid = 1'b0;
    checks++; if (bus.upd_sel !== 2'd1 || bus.count !== 4'd1) begin errors++; $display("[TB] FAIL mis_global got sel=%0d count=%0d want 1 1", bus.upd_sel, bus.count); end
    @(negedge clock);
    checks++; if (bus.upd_sel !== 2'd2 || bus.upd_taken !== 1'b1 || bus.ghr_restore_valid !== 1'b0) begin errors++; $display("[TB] FAIL mis_choice got sel=%0d t=%0b grv=%0b want 2 1 0", bus.upd_sel, bus.upd_taken, bus.ghr_restore_valid); end
    @(negedge clock);
    checks++; if (bus.ghr_restore_valid !== 1'b1 || bus.flush !== 1'b1 || bus.upd_valid !== 1'b0) begin errors++; $display("[TB] FAIL mis_recover got grv=%0b fl=%0b v=%0b want 1 1 0", bus.ghr_restore_valid, bus.flush, bus.upd_valid); end
    checks++; if (bus.ghr_restore_value !== 12'h14A) begin errors++; $display("[TB] FAIL mis_restore_value got %h want 14a", bus.ghr_restore_value); end
    checks++; if (bus.pred_ready !== 1'b0 || bus.res_ready !== 1'b0) begin errors++; $display("[TB] FAIL mis_ready_recover got pr=%0b rr=%0b want 0 0", bus.pred_ready, bus.res_ready); end
    @(negedge clock);
    checks++; if (bus.count !== 4'd0 || bus.flush !== 1'b0 || bus.ghr_restore_valid !== 1'b0) begin errors++; $display("[TB] FAIL mis_after got count=%0d fl=%0b grv=%0b want 0 0 0", bus.count, bus.flush, bus.ghr_restore_valid); end
    checks++; if (bus.pred_ready !== 1'b1) begin errors++; $display("[TB] FAIL mis_pred_ready_after got %0b want 1", bus.pred_ready); end
  endtask

  // Fill the queue, push+resolve at full, then stall in UPD_GLOBAL.
  task automatic test_full_and_stall();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_pred(32'h300 + 32'(i), 12'h040 + 12'(i), 1'b1, 1'b0, 1'b1);
      @(negedge clock);
    end
    drive_pred(32'h3FF, 12'hFFF, 1'b1, 1'b0, 1'b1);
    checks++; if (bus.count !== 4'd8 || bus.pred_ready !== 1'b0) begin errors++; $display("[TB] FAIL full got count=%0d pr=%0b want 8 0", bus.count, bus.pred_ready); end
    bus.res_valid = 1'b1; bus.res_taken = 1'b1; bus.upd_ready = 1'b0;
    @(negedge clock);
    bus.pred_valid = 1'b0; bus.res_valid = 1'b0;
    checks++; if (bus.count !== 4'd7) begin errors++; $display("[TB] FAIL full_push_pop got count=%0d want 7", bus.count); end
    checks++; if (bus.upd_valid !== 1'b1 || bus.upd_sel !== 2'd0 || bus.upd_pc !== 32'h300) begin errors++; $display("[TB] FAIL full_head got v=%0b sel=%0d pc=%h want 1 0 300", bus.upd_valid, bus.upd_sel, bus.upd_pc); end
    bus.upd_ready = 1'b1;
    @(negedge clock);
    bus.upd_ready = 1'b0;
    bus.res_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++; if (bus.upd_valid !== 1'b1 || bus.upd_sel !== 2'd1 || bus.upd_pc !== 32'h300 || bus.upd_ghr !== 12'h040 || bus.upd_taken !== 1'b1) begin errors++; $display("[TB] FAIL stall_hold_%0d got v=%0b sel=%0d pc=%h ghr=%h t=%0b want 1 1 300 040 1", i, bus.upd_valid, bus.upd_sel, bus.upd_pc, bus.upd_ghr, bus.upd_taken); end
      checks++; if (bus.res_ready !== 1'b0 || bus.count !== 4'd7) begin errors++; $display("[TB] FAIL stall_res_%0d got rr=%0b count=%0d want 0 7", i, bus.res_ready, bus.count); end
    end
    bus.res_valid = 1'b0;
    bus.upd_ready = 1'b1;
    @(negedge clock);
    checks++; if (bus.upd_sel !== 2'd2 || bus.upd_taken !== 1'b0) begin errors++; $display("[TB] FAIL stall_choice got sel=%0d t=%0b want 2 0", bus.upd_sel, bus.upd_taken); end
    @(negedge clock);
    checks++; if (bus.upd_valid !== 1'b0 || bus.flush !== 1'b0 || bus.count !== 4'd7) begin errors++; $display("[TB] FAIL stall_idle got v=%0b fl=%0b count=%0d want 0 0 7", bus.upd_valid, bus.flush, bus.count); end
  endtask

  // local == global, correct resolve: CHOICE skipped only with the filter build.
  task automatic test_choice_filter();
    int hs;
    int fl;
    int expected;
`ifdef BP_UPD_CHOICE_FILTER_EN
    expected = 2;
`else
    expected = 3;
`endif
    hs = 0;
    fl = 0;
    do_reset();
    drive_pred(32'h400, 12'h123, 1'b1, 1'b1, 1'b1); @(negedge clock);
    bus.pred_valid = 1'b0;
    bus.res_valid = 1'b1; bus.res_taken = 1'b1; bus.upd_ready = 1'b1;
    @(negedge clock);
    bus.res_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.upd_valid === 1'b1 && bus.upd_ready === 1'b1) hs++;
      if (bus.flush !== 1'b0) fl++;
      @(negedge clock);
    end
    checks++; if (hs !== expected) begin errors++; $display("[TB] FAIL filter_handshakes got %0d want %0d", hs, expected); end
    checks++; if (fl !== 0) begin errors++; $display("[TB] FAIL filter_flush got %0d cycles want 0", fl); end
  endtask

  // Reset in the middle of UPD_LOCAL abandons the update.
  task automatic test_reset_mid();
    int seen;
    seen = 0;
    do_reset();
    drive_pred(32'h500, 12'h055, 1'b1, 1'b0, 1'b1); @(negedge clock);
    drive_pred(32'h504, 12'h066, 1'b1, 1'b0, 1'b1); @(negedge clock);
    bus.pred_valid = 1'b0;
    bus.res_valid = 1'b1; bus.res_taken = 1'b1; bus.upd_ready = 1'b0;
    @(negedge clock);
    bus.res_valid = 1'b0;
    checks++; if (bus.upd_valid !== 1'b1 || bus.upd_sel !== 2'd0) begin errors++; $display("[TB] FAIL rmid_pre got v=%0b sel=%0d want 1 0", bus.upd_valid, bus.upd_sel); end
    reset = 1'b0;
    #1;
    checks++; if (bus.upd_valid !== 1'b0 || bus.count !== 4'd0 || bus.pred_ready !== 1'b0 || bus.res_ready !== 1'b0) begin errors++; $display("[TB] FAIL rmid_async got v=%0b count=%0d pr=%0b rr=%0b want 0 0 0 0", bus.upd_valid, bus.count, bus.pred_ready, bus.res_ready); end
    checks++; if (bus.upd_pc !== 32'd0 || bus.upd_ghr !== 12'd0 || bus.flush !== 1'b0) begin errors++; $display("[TB] FAIL rmid_data got pc=%h ghr=%h fl=%0b want 0 0 0", bus.upd_pc, bus.upd_ghr, bus.flush); end
    @(negedge clock);
    reset = 1'b1;
    bus.upd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (bus.upd_valid !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL rmid_no_update got %0d cycles want 0", seen); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("[TB] FAIL rmid_count got %0d want 0", bus.count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    clear_inputs();
    test_reset();
    test_correct();
    test_mispredict();
    test_full_and_stall();
    test_choice_filter();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
